// File: rtl/vram_rect_fill_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_rect_fill_if
// Brief    : Command handshake and VRAM write-port bundle for vram_rect_fill.
//            master = command source / VRAM side, slave = the fill engine.
// Revision : 1.0 - initial release
// ============================================================================
interface vram_rect_fill_if #(
    parameter int COORD_W = 7,
    parameter int COLOR_W = 4
);
    // Command channel
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [COORD_W-1:0]     cmd_x;
    logic [COORD_W-1:0]     cmd_y;
    logic [COORD_W:0]       cmd_w;
    logic [COORD_W:0]       cmd_h;
    logic [COLOR_W-1:0]     cmd_color;

    // VRAM write port and status
    logic                   vram_we;
    logic [2*COORD_W-1:0]   vram_addr;
    logic [COLOR_W-1:0]     vram_din;
    logic                   busy;
    logic                   done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, vram_we, vram_addr, vram_din, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, vram_we, vram_addr, vram_din, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/vram_rect_fill.sv
`default_nettype none
// ============================================================================
// Module   : vram_rect_fill
// Brief    : Rectangle-fill drawing engine for the square Pico VRAM. Accepts
//            one command at a time and writes one pixel per clock in
//            row-major order. Coordinates wrap modulo the VRAM size unless
//            VRAM_RECT_FILL_CLIP_EN is defined, in which case the rectangle
//            is clipped at the right and bottom edges instead.
// Revision : 1.0 - initial release
// ============================================================================
module vram_rect_fill #(
    parameter int COORD_W = 7,
    parameter int COLOR_W = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    vram_rect_fill_if.slave     bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    // VRAM side length and a one in offset-counter width
    localparam logic [COORD_W:0] c_SIZE = {1'b1, {COORD_W{1'b0}}};
    localparam logic [COORD_W:0] c_ONE  = {{COORD_W{1'b0}}, 1'b1};

    logic [0:0]             r_state, w_state_n;
    logic [COORD_W-1:0]     r_x0, w_x0_n;
    logic [COORD_W-1:0]     r_y0, w_y0_n;
    logic [COORD_W:0]       r_w, w_w_n;
    logic [COORD_W:0]       r_h, w_h_n;
    logic [COORD_W:0]       r_col, w_col_n;
    logic [COORD_W:0]       r_row, w_row_n;
    logic                   r_we, w_we_n;
    logic [2*COORD_W-1:0]   r_addr, w_addr_n;
    logic [COLOR_W-1:0]     r_din, w_din_n;
    logic                   r_busy, w_busy_n;
    logic                   r_done, w_done_n;

    logic [COORD_W:0]       w_lim_w;
    logic [COORD_W:0]       w_lim_h;
    logic [COORD_W:0]       w_eff_w;
    logic [COORD_W:0]       w_eff_h;
    logic                   w_accept;
    logic                   w_empty;
    logic                   w_last_col;
    logic                   w_last_row;
    logic [COORD_W-1:0]     w_col_sum;
    logic [COORD_W-1:0]     w_row_sum;

`ifdef VRAM_RECT_FILL_CLIP_EN
    // Clipping: the rectangle may not extend past the right/bottom edge
    assign w_lim_w = c_SIZE - {1'b0, bus.cmd_x};
    assign w_lim_h = c_SIZE - {1'b0, bus.cmd_y};
`else
    // Wrap-around: only the VRAM size itself bounds the rectangle
    assign w_lim_w = c_SIZE;
    assign w_lim_h = c_SIZE;
`endif

    assign w_eff_w    = (bus.cmd_w > w_lim_w) ? w_lim_w : bus.cmd_w;
    assign w_eff_h    = (bus.cmd_h > w_lim_h) ? w_lim_h : bus.cmd_h;
    assign w_empty    = (w_eff_w == '0) || (w_eff_h == '0);
    assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);

    // r_col/r_row are the offsets of the pixel currently on the write port
    assign w_last_col = (r_col == (r_w - c_ONE));
    assign w_last_row = (r_row == (r_h - c_ONE));

    // Next-state, counter and output-register logic
    always_comb begin
        w_state_n = r_state;
        w_x0_n    = r_x0;
        w_y0_n    = r_y0;
        w_w_n     = r_w;
        w_h_n     = r_h;
        w_col_n   = r_col;
        w_row_n   = r_row;
        w_we_n    = 1'b0;
        w_addr_n  = r_addr;
        w_din_n   = r_din;
        w_busy_n  = 1'b0;
        w_done_n  = 1'b0;
        w_col_sum = '0;
        w_row_sum = '0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_x0_n  = bus.cmd_x;
                    w_y0_n  = bus.cmd_y;
                    w_w_n   = w_eff_w;
                    w_h_n   = w_eff_h;
                    w_col_n = '0;
                    w_row_n = '0;
                    if (w_empty) begin
                        w_done_n = 1'b1;
                    end else begin
                        // First pixel goes out on the acceptance edge
                        w_state_n = S_FILL;
                        w_we_n    = 1'b1;
                        w_busy_n  = 1'b1;
                        w_addr_n  = {bus.cmd_y, bus.cmd_x};
                        w_din_n   = bus.cmd_color;
                    end
                end
            end

            S_FILL: begin
                if (w_last_col && w_last_row) begin
                    w_state_n = S_IDLE;
                    w_done_n  = 1'b1;
                end else begin
                    if (w_last_col) begin
                        w_col_n = '0;
                        w_row_n = r_row + c_ONE;
                    end else begin
                        w_col_n = r_col + c_ONE;
                    end
                    // Low bits of the sums give the modulo-size wrap
                    w_col_sum = r_x0 + w_col_n[COORD_W-1:0];
                    w_row_sum = r_y0 + w_row_n[COORD_W-1:0];
                    w_we_n    = 1'b1;
                    w_busy_n  = 1'b1;
                    w_addr_n  = {w_row_sum, w_col_sum};
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_x0    <= w_x0_n;
            r_y0    <= w_y0_n;
            r_w     <= w_w_n;
            r_h     <= w_h_n;
            r_col   <= w_col_n;
            r_row   <= w_row_n;
            r_we    <= w_we_n;
            r_addr  <= w_addr_n;
            r_din   <= w_din_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.vram_we   = r_we;
    assign bus.vram_addr = r_addr;
    assign bus.vram_din  = r_din;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: doc/vram_rect_fill.md
Name: vram_rect_fill

Overview:
- Upstream drawing engine for the 128x128, 4-bit-per-pixel Pico video RAM.
- Accepts rectangle-fill commands over a valid/ready handshake.
- Drives the VRAM write port (write address, data, write enable) at one pixel per clock.
- The read side and the scan-out are unaffected. The block gives the VRAM write port a real driver in place of the tied-off constants.

Parameters:
- COORD_W, 7, width of x/y coordinates (VRAM is 2^COORD_W pixels square)
- COLOR_W, 4, pixel colour width, matches VRAM word width

Ports:
- clk  in  1  system clock (same clock as VRAM and VGA sync)
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x  in  7  left column of rectangle
- cmd_y  in  7  top row of rectangle
- cmd_w  in  8  width in pixels, 0..255
- cmd_h  in  8  height in pixels, 0..255
- cmd_color  in  4  fill colour
- vram_we  out  1  VRAM write enable
- vram_addr  out  14  VRAM write address, {row[6:0], col[6:0]}
- vram_din  out  4  VRAM write data
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset values: state IDLE, vram_we 0, vram_addr 0, vram_din 0, busy 0, done 0. cmd_ready is 1 from the first cycle after reset.
- cmd_ready is 1 exactly when the state is IDLE. A command is accepted on a rising edge where cmd_valid && cmd_ready. All cmd_* fields are latched at acceptance.
- Dimension rules, applied at acceptance:
  - w_eff = min(cmd_w, 128); h_eff = min(cmd_h, 128).
  - If w_eff == 0 or h_eff == 0: no writes; done pulses in the next cycle; state stays IDLE.
- States: IDLE -> FILL on acceptance of a non-empty command. FILL -> IDLE after the last pixel is written.
- FILL timing:
  - First write (vram_we=1) is in the cycle after acceptance (1-cycle latency).
  - Each FILL cycle writes one pixel: addr = {(y0+row_off) mod 128, (x0+col_off) mod 128}, din = latched colour.
  - Scan order is row-major: col_off 0..w_eff-1, then col_off resets to 0 and row_off increments.
- Completion:
  - The last write occurs at row_off == h_eff-1, col_off == w_eff-1.
  - In the following cycle: vram_we 0, busy 0, done 1 for one cycle, cmd_ready 1.
  - A command presented in that cycle is accepted (back-to-back).
- Totals: exactly w_eff*h_eff write cycles. Acceptance to done = w_eff*h_eff + 1 cycles.
- Outputs:
  - vram_we, vram_addr, vram_din, busy and done are registered.
  - vram_addr/vram_din hold their last values when vram_we is 0.
- busy is 1 in every cycle where vram_we is 1, and 0 otherwise.
- cmd_valid while busy: ignored. No overflow and no queuing; the source must hold the command.
- Reset mid-fill: on the reset edge, state goes to IDLE and vram_we 0. Remaining pixels are abandoned and no done pulse is issued.
- Wrap-around (default build): coordinates wrap modulo 128 in both axes. A 128-wide fill therefore covers a full row regardless of x.
- Arithmetic: offsets are 8-bit counters. Addresses are formed from the low 7 bits of the sums.

Optional Feature:
- Macro: VRAM_RECT_FILL_CLIP_EN.
- Defined: clipping replaces wrap-around. At acceptance, w_eff = min(cmd_w, 128-cmd_x) and h_eff = min(cmd_h, 128-cmd_y). Pixels off the right or bottom edge are neither written nor spend cycles. A fully clipped command behaves as an empty command (done next cycle, no writes).
- Not defined: coordinates wrap modulo 128 as described in Behaviour.

Test Plan:
- Reset, then cmd (x=10, y=20, w=2, h=2, color=0xA) -> writes to addrs 2570, 2571, 2698, 2699 on cycles 1-4 after acceptance, din 0xA. done=1 on cycle 5; busy low after.
- cmd w=0, h=5 -> no vram_we; done pulse 1 cycle after acceptance; cmd_ready stays 1.
- cmd (0, 0, 128, 128, 0x0) -> 16384 consecutive writes, addrs 0..16383 in order, done at cycle 16385. cmd w=200, h=1 -> exactly 128 writes.
- cmd (x=126, y=0, w=4, h=1) -> default build: addrs 126, 127, 0, 1. With VRAM_RECT_FILL_CLIP_EN: addrs 126, 127 only, done at cycle 3.
- Hold cmd_valid with a second command during a fill -> second command not accepted until the done cycle, then accepted. Its first write follows done by 1 cycle.
- Assert rst after the 3rd write of a 4x4 fill -> vram_we 0 from the next cycle, no done pulse, cmd_ready 1; a new command is accepted normally.
